// File: rtl/div_unit.sv
// Radix-2 restoring integer divider (div.w/mod.w/div.wu/mod.wu), one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: finish at acceptance for zero divisors and |src1| < |src2|.
module div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  div_signed,
    input  logic [DATA_WIDTH-1:0] div_src1,
    input  logic [DATA_WIDTH-1:0] div_src2,
    input  logic                  cancel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] div_quot,
    output logic [DATA_WIDTH-1:0] div_rem
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state;
    logic [CNT_W-1:0]      counter;
    logic [DATA_WIDTH-1:0] rem_r;
    logic [DATA_WIDTH-1:0] dvd_r;
    logic [DATA_WIDTH-1:0] dvs_abs;
    logic [DATA_WIDTH-1:0] src1_r;
    logic                  quot_neg;
    logic                  rem_neg;
    logic                  div_zero;

    logic                  src1_neg;
    logic                  src2_neg;
    logic [DATA_WIDTH-1:0] src1_abs;
    logic [DATA_WIDTH-1:0] src2_abs;
    logic [DATA_WIDTH:0]   partial;
    logic [DATA_WIDTH:0]   trial;
    logic                  no_borrow;
    logic [DATA_WIDTH-1:0] rem_next;
    logic [DATA_WIDTH-1:0] quo_next;
    logic [DATA_WIDTH-1:0] fix_quot;
    logic [DATA_WIDTH-1:0] fix_rem;
    logic [DATA_WIDTH-1:0] final_quot;
    logic [DATA_WIDTH-1:0] final_rem;
    logic                  last_iter;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    assign src1_neg = div_signed & div_src1[DATA_WIDTH-1];
    assign src2_neg = div_signed & div_src2[DATA_WIDTH-1];
    assign src1_abs = src1_neg ? (~div_src1 + 1'b1) : div_src1;
    assign src2_abs = src2_neg ? (~div_src2 + 1'b1) : div_src2;

    // The quotient bits shift into the low end of dvd_r as the dividend bits leave the top.
    assign partial   = {rem_r, dvd_r[DATA_WIDTH-1]};
    assign trial     = partial - {1'b0, dvs_abs};
    assign no_borrow = ~trial[DATA_WIDTH];
    assign rem_next  = no_borrow ? trial[DATA_WIDTH-1:0] : partial[DATA_WIDTH-1:0];
    assign quo_next  = {dvd_r[DATA_WIDTH-2:0], no_borrow};
    assign last_iter = (counter == CNT_W'(DATA_WIDTH - 1));

    assign fix_quot   = quot_neg ? (~quo_next + 1'b1) : quo_next;
    assign fix_rem    = rem_neg  ? (~rem_next + 1'b1) : rem_next;
    assign final_quot = div_zero ? {DATA_WIDTH{1'b1}} : fix_quot;
    assign final_rem  = div_zero ? src1_r : fix_rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            counter  <= '0;
            rem_r    <= '0;
            dvd_r    <= '0;
            dvs_abs  <= '0;
            src1_r   <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            div_quot <= '0;
            div_rem  <= '0;
        end else if (cancel) begin
            state   <= ST_IDLE;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        src1_r   <= div_src1;
                        dvd_r    <= src1_abs;
                        rem_r    <= '0;
                        dvs_abs  <= src2_abs;
                        quot_neg <= div_signed & (div_src1[DATA_WIDTH-1] ^ div_src2[DATA_WIDTH-1]);
                        rem_neg  <= src1_neg;
                        div_zero <= (div_src2 == '0);
                        counter  <= '0;
`ifdef DIV_EARLY_OUT_EN
                        // Trivial results are known at acceptance, so skip the iterations.
                        if ((div_src2 == '0) || (src1_abs < src2_abs)) begin
                            state    <= ST_DONE;
                            div_quot <= (div_src2 == '0) ? {DATA_WIDTH{1'b1}} : '0;
                            div_rem  <= div_src1;
                        end else begin
                            state <= ST_BUSY;
                        end
`else
                        state <= ST_BUSY;
`endif
                    end
                end
                ST_BUSY: begin
                    rem_r <= rem_next;
                    dvd_r <= quo_next;
                    if (last_iter) begin
                        counter  <= '0;
                        state    <= ST_DONE;
                        div_quot <= final_quot;
                        div_rem  <= final_rem;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomised scoreboard bench for div_unit: a driver pushes reference results, a monitor pops on handshake.
// Honours DIV_EARLY_OUT_EN when computing the expected latency.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic         div_signed;
    logic [W-1:0] div_src1;
    logic [W-1:0] div_src2;
    logic         cancel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] div_quot;
    logic [W-1:0] div_rem;

    typedef struct {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        int           lat;
        int           acc_cyc;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           pass_cnt  = 0;
    int           total_cnt = 0;
    int           cyc       = 0;
    logic         bp_req    = 1'b0;
    logic         bp_active = 1'b0;
    logic         prev_ov   = 1'b0;
    logic         chk_idle  = 1'b0;
    logic [W-1:0] hold_q    = '0;
    logic [W-1:0] hold_r    = '0;

    div_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .div_signed (div_signed),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .cancel     (cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic, with the zero-divisor rule applied on top.
    function automatic exp_t refModel(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint na, nb, q, r, aa, ab;
        na = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        nb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (b == '0) begin
            e.quot = '1;
            e.rem  = a;
        end else begin
            q = na / nb;
            r = na % nb;
            e.quot = q[W-1:0];
            e.rem  = r[W-1:0];
        end
        aa = (na < 0) ? -na : na;
        ab = (nb < 0) ? -nb : nb;
`ifdef DIV_EARLY_OUT_EN
        e.lat = ((b == '0) || (aa < ab)) ? 0 : W;
`else
        e.lat = W;
`endif
        e.acc_cyc = 0;
        e.name    = "";
        return e;
    endfunction

    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input string name);
        exp_t e;
        int   n = 0;
        @(posedge clk); #1;
        in_valid   = 1'b1;
        div_signed = sgn;
        div_src1   = a;
        div_src2   = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 500) begin
                checkOutput({name, " accept timeout"}, {31'b0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = refModel(sgn, a, b);
        e.acc_cyc = cyc;
        e.name    = name;
        sb_q.push_back(e);
    endtask

    // Consumer: random backpressure, plus one forced 10-cycle stall on request.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bp_req && out_valid) begin
                out_ready = 1'b0;
                bp_req    = 1'b0;
                bp_active = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                bp_active = 1'b0;
                out_ready = 1'b1;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor: latency on the rising out_valid, stability under stall, results on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_ov  = 1'b0;
                chk_idle = 1'b0;
            end else begin
                if (chk_idle) begin
                    checkOutput("in_ready after handshake", {31'b0, in_ready}, 32'd1);
                    chk_idle = 1'b0;
                end
                if (out_valid && !prev_ov) begin
                    if (sb_q.size() == 0)
                        checkOutput("unexpected out_valid", {31'b0, out_valid}, 32'd0);
                    else
                        checkOutput({sb_q[0].name, " latency"}, W'(cyc - sb_q[0].acc_cyc), W'(sb_q[0].lat));
                    hold_q = div_quot;
                    hold_r = div_rem;
                end
                if (out_valid && bp_active) begin
                    checkOutput("stall quot stable", div_quot, hold_q);
                    checkOutput("stall rem stable", div_rem, hold_r);
                    checkOutput("stall in_ready low", {31'b0, in_ready}, 32'd0);
                end
                if (out_valid && out_ready && sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    checkOutput({mon_e.name, " quot"}, div_quot, mon_e.quot);
                    checkOutput({mon_e.name, " rem"}, div_rem, mon_e.rem);
                    chk_idle = 1'b1;
                end
                prev_ov = out_valid;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got %0d pending, expected 0", sb_q.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic         ov_seen;
        logic         sgn;
        logic [W-1:0] a, b;
        int           n;

        resetn     = 1'b0;
        in_valid   = 1'b0;
        div_signed = 1'b0;
        div_src1   = '0;
        div_src2   = '0;
        cancel     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset quot", div_quot, 32'd0);
        checkOutput("reset rem", div_rem, 32'd0);
        resetn = 1'b1;

        applyStimulus(1'b0, 32'd100, 32'd7, "u 100/7");
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, "s -7/2");
        applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2, "u 0xFFFFFFF9/2");
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, "s overflow");
        applyStimulus(1'b0, 32'd5, 32'd0, "u 5/0");
        applyStimulus(1'b1, 32'hFFFFFFF0, 32'd0, "s -16/0");
        applyStimulus(1'b1, 32'd3, 32'd10, "s 3/10");
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, "s -100/-7");

        applyStimulus(1'b0, 32'd1234567, 32'd89, "stalled op");
        bp_req = 1'b1;

        // Abort an operation mid-flight; it must never produce a result.
        applyStimulus(1'b0, 32'd1000, 32'd3, "cancelled op");
        void'(sb_q.pop_back());
        repeat (14) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel in_ready", {31'b0, in_ready}, 32'd1);
        ov_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            ov_seen = ov_seen | out_valid;
        end
        checkOutput("cancel no out_valid", {31'b0, ov_seen}, 32'd0);
        applyStimulus(1'b0, 32'd9, 32'd3, "u 9/3 after cancel");

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(0, 200);
                1:       a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            applyStimulus(sgn, a, b, $sformatf("rand%0d", i));
        end

        // Reset in the middle of an operation drops it and restores reset values.
        applyStimulus(1'b0, 32'd777, 32'd5, "reset op");
        void'(sb_q.pop_back());
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midreset in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midreset out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midreset quot", div_quot, 32'd0);
        checkOutput("midreset rem", div_rem, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        applyStimulus(1'b1, 32'hFFFFFF85, 32'd10, "s -123/10 after reset");

        n = 0;
        while (sb_q.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        checkOutput("drain pending", W'(sb_q.size()), 32'd0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
